// File: rtl/seq_countdown_clock_pkg.sv
// Shared field types, constants and time struct for the 12-hour countdown clock.
// Also provides the range check used for time and alarm loads.
package seq_countdown_clock_pkg;

   localparam int HOURS_W = 4;
   localparam int MINS_W  = 6;

   typedef logic [HOURS_W-1:0] hours_t;
   typedef logic [MINS_W-1:0]  mins_t;

   localparam hours_t HOURS_RESET = 4'd12;
   localparam hours_t HOURS_MIN   = 4'd1;
   localparam mins_t  MINS_MAX    = 6'd59;

   typedef struct packed {
      hours_t hours;
      mins_t  mins;
      logic   pm;
   } time_t;

   localparam time_t TIME_RESET = '{hours: HOURS_RESET, mins: 6'd0, pm: 1'b0};

   function automatic logic time_valid(input hours_t h, input mins_t m);
      return (h >= HOURS_MIN) && (h <= HOURS_RESET) && (m <= MINS_MAX);
   endfunction

endpackage

// File: rtl/seq_countdown_clock_dec.sv
// Combinational one-minute decrement of a 12-hour time, 12:00am wraps to 11:59pm.
// Input is assumed in range; the output then stays in range as well.
module seq_countdown_clock_dec
   import seq_countdown_clock_pkg::*;
(
   input  time_t cur_i,
   output time_t nxt_o
);

   // Minute borrow, then hour step; pm flips only on the 12 -> 11 step
   always_comb begin
      nxt_o = cur_i;
      if (cur_i.mins != 6'd0) begin
         nxt_o.mins = cur_i.mins - 6'd1;
      end else begin
         nxt_o.mins = MINS_MAX;
         if (cur_i.hours == HOURS_MIN) begin
            nxt_o.hours = HOURS_RESET;
         end else if (cur_i.hours == HOURS_RESET) begin
            nxt_o.hours = 4'd11;
            nxt_o.pm    = ~cur_i.pm;
         end else begin
            nxt_o.hours = cur_i.hours - 4'd1;
         end
      end
   end

endmodule

// File: rtl/seq_countdown_clock.sv
// Reverse-running 12-hour clock with set validation and registered outputs.
// Optional alarm comparator enabled by defining SEQ_COUNTDOWN_CLOCK_ALARM_EN.
module seq_countdown_clock
   import seq_countdown_clock_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       set_en,
   input  logic [3:0] set_hours,
   input  logic [5:0] set_mins,
   input  logic       set_pm,
`ifdef SEQ_COUNTDOWN_CLOCK_ALARM_EN
   input  logic       alarm_set_en,
   input  logic [3:0] alarm_hours,
   input  logic [5:0] alarm_mins,
   input  logic       alarm_pm,
   input  logic       alarm_disarm,
   output logic       alarm_hit,
`endif
   output logic [3:0] hours,
   output logic [5:0] mins,
   output logic       pm,
   output logic       set_err
);

   time_t time_q, time_d;
   time_t dec_s;
   logic  set_err_q, set_err_d;
   logic  set_ok_s;
   logic  tick_apply_s;
   logic  alarm_err_s;

   seq_countdown_clock_dec u_dec (
      .cur_i (time_q),
      .nxt_o (dec_s)
   );

   assign set_ok_s     = time_valid(set_hours, set_mins);
   assign tick_apply_s = tick & ~set_en;

   // Next time: set beats tick beats hold; a rejected set also swallows the tick
   always_comb begin
      time_d = time_q;
      if (set_en) begin
         if (set_ok_s) begin
            time_d = '{hours: set_hours, mins: set_mins, pm: set_pm};
         end else begin
            time_d = time_q;
         end
      end else if (tick) begin
         time_d = dec_s;
      end else begin
         time_d = time_q;
      end
   end

   // Error pulse covers both the time load and the alarm load
   always_comb begin
      set_err_d = (set_en & ~set_ok_s) | alarm_err_s;
   end

   // Time and error registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         time_q    <= TIME_RESET;
         set_err_q <= 1'b0;
      end else begin
         time_q    <= time_d;
         set_err_q <= set_err_d;
      end
   end

   assign hours   = time_q.hours;
   assign mins    = time_q.mins;
   assign pm      = time_q.pm;
   assign set_err = set_err_q;

`ifdef SEQ_COUNTDOWN_CLOCK_ALARM_EN
   time_t alarm_q, alarm_d;
   logic  armed_q, armed_d;
   logic  hit_q, hit_d;
   logic  alarm_ok_s;

   assign alarm_ok_s = time_valid(alarm_hours, alarm_mins);

   // Hit only on a tick-produced match; a fresh alarm load overrides auto-disarm
   always_comb begin
      alarm_d     = alarm_q;
      armed_d     = armed_q;
      hit_d       = 1'b0;
      alarm_err_s = 1'b0;
      if (tick_apply_s && armed_q && (dec_s == alarm_q)) begin
         hit_d   = 1'b1;
         armed_d = 1'b0;
      end else begin
         hit_d   = 1'b0;
      end
      if (alarm_set_en) begin
         if (alarm_ok_s) begin
            alarm_d = '{hours: alarm_hours, mins: alarm_mins, pm: alarm_pm};
            armed_d = 1'b1;
         end else begin
            alarm_err_s = 1'b1;
         end
      end else if (alarm_disarm) begin
         armed_d = 1'b0;
      end else begin
         alarm_d = alarm_d;
      end
   end

   // Alarm registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_q <= TIME_RESET;
         armed_q <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
         armed_q <= armed_d;
         hit_q   <= hit_d;
      end
   end

   assign alarm_hit = hit_q;
`else
   assign alarm_err_s = 1'b0;
   logic  unused_s;
   assign unused_s = tick_apply_s;
`endif

endmodule

// File: doc/seq_countdown_clock.md
# seq_countdown_clock

Reverse-running 12-hour clock: holds a time (hours 1–12, minutes 0–59, am/pm) and decrements it by one minute per tick, wrapping 12:00am back to 11:59pm. It is the counting-down counterpart of the forward 12-hour clock and shares its set/tick interface and output encoding, so either block can drive the same display logic. An optional alarm comparator flags when the countdown reaches a programmed time.

## Interface
- No parameters; field widths come from the shared package.
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick  input  1  decrement by one minute this cycle.
- set_en  input  1  load set_hours/set_mins/set_pm this cycle.
- set_hours  input  4  hour to load, valid range 1–12.
- set_mins  input  6  minute to load, valid range 0–59.
- set_pm  input  1  am/pm to load (1 = pm).
- hours  output  4  current hour, 1–12.
- mins  output  6  current minute, 0–59.
- pm  output  1  current am/pm.
- set_err  output  1  one-cycle pulse: last set request was rejected.
- Alarm build only: alarm_set_en  input  1; alarm_hours  input  4; alarm_mins  input  6; alarm_pm  input  1; alarm_disarm  input  1; alarm_hit  output  1.

## Operation
- Reset (reset_n low, asynchronous): hours=12, mins=0, pm=0, set_err=0; alarm registers 12:00am and disarmed; alarm_hit=0.
- Priority per cycle: set_en > tick > hold.
- Set: if 1≤set_hours≤12 and set_mins≤59, load all three fields; tick ignored that cycle; set_err=0. Otherwise, hold state, set_err=1 for one cycle, and tick is still ignored.
- Decrement on tick (no set_en):
  - mins>0: mins−1.
  - mins=0: mins=59, then hour step.
  - Hour step: hours=1 → 12; hours=12 → 11 and pm toggles; else hours−1.
  - So 12:00am → 11:59pm, 12:00pm → 11:59am, 1:00pm → 12:59pm (pm unchanged).
- No other state; no FSM beyond the time registers.
- Arithmetic: compare and decrement at native widths; the 4-bit and 6-bit fields never hold out-of-range values.

## Timing
- All outputs are registered. Set or tick sampled at edge k is visible after edge k (1-cycle latency).
- set_err is high only for the cycle following the rejected request.
- Back-to-back ticks decrement every cycle with no bubbles.
- reset_n assertion mid-operation clears state immediately. The first edge after deassertion may apply set/tick.

## Configuration
- Macro SEQ_COUNTDOWN_CLOCK_ALARM_EN.
- Defined:
  - Alarm ports and registers exist.
  - alarm_set_en loads the alarm time (same range check; a bad value is ignored and pulses set_err) and arms the alarm.
  - alarm_disarm clears the armed state. alarm_set_en wins if both are asserted.
  - alarm_hit is registered. It is 1 for exactly the cycle in which the outputs first show a tick-produced time equal to the armed alarm time. It is then disarmed automatically.
  - Reaching the alarm time via set_en does not fire the alarm.
- Undefined: alarm ports absent; core behaviour identical.

## Structure
- Shared package: hour/min field typedefs, constants HOURS_RESET=12, MINS_MAX=59, and a time struct {hours, mins, pm}.
- Sub-module seq_countdown_clock_dec: combinational next-time decrement (time struct in → time struct out), reusable by the alarm compare.
- Top level: set validation, priority mux, registers, and the optional alarm.

## Test plan
- Reset, no tick for 3 cycles → 12:00am held; set_err=0.
- Set 1:02am, then 4 ticks → 1:01am, 1:00am, 12:59am, 12:58am; pm=0 throughout.
- Set 12:01am, then 2 ticks → 12:00am, 11:59pm (pm=1). Set 12:00pm, then 1 tick → 11:59am (pm=0).
- Set 13:00, then set 5:60 (both rejected) → set_err pulses once each; time unchanged. set_en with tick on a valid set → loaded value shown, no decrement.
- reset_n low during a tick stream at 7:30pm → immediately 12:00am; ticks resume after deassertion (→ 11:59pm).
- ALARM_EN: alarm 10:28pm, set 10:30pm, then 3 ticks → alarm_hit=1 only in the cycle showing 10:28pm. Setting directly to 10:28pm does not fire; alarm_disarm before reaching it suppresses the hit.
